// File: rtl/avl_bus_slave_ram.sv
// Burst-capable Avalon-style slave in front of a single-port word RAM.
// Read data returns through an in-order response FIFO that resp_ready can back-pressure.
module avl_bus_slave_ram #(
    parameter int ADDR_WIDTH      = 10,
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int BURST_MAX_COUNT = 16
) (
    input  logic        i_clk,
    input  logic        i_rest,
    input  logic [31:0] i_address,
    input  logic [3:0]  i_byte_en,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_write_data,
    input  logic        i_begin_burst_transfer,
    input  logic [7:0]  i_burst_count,
    output logic        o_request_ready,
    output logic [31:0] o_read_data,
    output logic        o_read_data_valid,
    input  logic        i_resp_ready,
    output logic        o_burst_err
);

    localparam int PW = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [31:0]           r_mem [2**ADDR_WIDTH];
    logic [31:0]           r_ram_q;
    logic                  r_rd_pend;
    logic [31:0]           r_fifo [RESP_FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_dir_wr;
    logic [31:0]           r_exp_addr;
    logic [7:0]            r_remaining;
    logic                  r_burst_err;

    logic                  w_acc;
    logic                  w_do_rd;
    logic                  w_do_wr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_latch;
    logic                  w_step;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;

    // A read in the RAM pipeline counts against FIFO space so its word always has a slot.
    assign o_request_ready   = !i_rest && ((r_count + CW'(r_rd_pend)) < CW'(RESP_FIFO_DEPTH));
    assign w_acc             = (i_read || i_write) && o_request_ready;
    assign w_do_wr           = w_acc && i_write;
    assign w_do_rd           = w_acc && !i_write;
    assign w_idx             = i_address[ADDR_WIDTH+1:2];
    assign w_push            = r_rd_pend;
    assign o_read_data_valid = (r_count != '0);
    assign w_pop             = o_read_data_valid && i_resp_ready;
    assign o_read_data       = o_read_data_valid ? r_fifo[r_rd_ptr] : 32'd0;
    assign o_burst_err       = r_burst_err;

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (i_byte_en[b]) r_mem[w_idx][8*b +: 8] <= i_write_data[8*b +: 8];
            end
        end
        if (w_do_rd) r_ram_q <= r_mem[w_idx];
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_ram_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_rd_pend <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_rd_pend <= w_do_rd;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Burst tracker: state register
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_state     <= S_IDLE;
            r_dir_wr    <= 1'b0;
            r_exp_addr  <= 32'd0;
            r_remaining <= 8'd0;
            r_burst_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_err <= w_err;
            if (w_latch) begin
                r_dir_wr    <= i_write;
                r_exp_addr  <= i_address + 32'd4;
                r_remaining <= i_burst_count;
            end else if (w_step) begin
                r_exp_addr  <= r_exp_addr + 32'd4;
                r_remaining <= r_remaining - 8'd1;
            end
        end
    end

    // A begin beat always (re)starts tracking, even mid-burst.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_step      = 1'b0;
        if (w_acc) begin
            if (i_begin_burst_transfer) begin
                if (i_burst_count != 8'd0) begin
                    w_state_nxt = S_BURST;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end else if (r_state == S_BURST) begin
                w_step = 1'b1;
                if (r_remaining == 8'd1) w_state_nxt = S_IDLE;
            end
        end
    end

    always_comb begin
        w_err = 1'b0;
        if (w_acc) begin
            if (i_read && i_write) w_err = 1'b1;
            if (i_begin_burst_transfer && (i_burst_count > 8'(BURST_MAX_COUNT))) w_err = 1'b1;
            if (r_state == S_BURST) begin
                if (i_begin_burst_transfer) begin
                    w_err = 1'b1;
                end else if ((r_dir_wr != i_write) || (i_address != r_exp_addr) ||
                             (i_burst_count != (r_remaining - 8'd1))) begin
                    w_err = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_avl_bus_slave_ram.sv
// Randomized bench for avl_bus_slave_ram against a word-array / response-queue model.
module tb_avl_bus_slave_ram;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        begin_burst_transfer;
    logic [7:0]  burst_count;
    logic        request_ready;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        resp_ready;
    logic        burst_err;

    int n_cmp   = 0;
    int n_fail  = 0;
    int err_cnt = 0;

    logic [31:0] m_mem [0:(2**AW)-1];
    logic [31:0] exp_q [$];

    avl_bus_slave_ram #(.ADDR_WIDTH(AW), .RESP_FIFO_DEPTH(DEPTH), .BURST_MAX_COUNT(16)) dut (
        .i_clk                  (clk),
        .i_rest                 (rest),
        .i_address              (address),
        .i_byte_en              (byte_en),
        .i_read                 (read),
        .i_write                (write),
        .i_write_data           (write_data),
        .i_begin_burst_transfer (begin_burst_transfer),
        .i_burst_count          (burst_count),
        .o_request_ready        (request_ready),
        .o_read_data            (read_data),
        .o_read_data_valid      (read_data_valid),
        .i_resp_ready           (resp_ready),
        .o_burst_err            (burst_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (burst_err === 1'b1) err_cnt++;

    // Issue one beat starting at a negedge; returns at the negedge after it is accepted.
    task automatic do_beat(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           input bit bb, input logic [7:0] cnt);
        int n = 0;
        logic [31:0] w;
        logic [AW-1:0] idx;
        while (request_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (request_ready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_ready_timeout: request_ready=%b required 1", request_ready);
            return;
        end
        read = rd; write = wr; address = addr; write_data = data; byte_en = be;
        begin_burst_transfer = bb; burst_count = cnt;
        idx = addr[AW+1:2];
        if (wr) begin
            w = m_mem[idx];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
            m_mem[idx] = w;
        end else if (rd) begin
            exp_q.push_back(m_mem[idx]);
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0; begin_burst_transfer = 1'b0; burst_count = 8'd0;
    endtask

    // Consume n responses, checking order, data and hold-while-stalled.
    task automatic drain(input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [31:0] hd = 32'd0;
        logic [31:0] e;
        while (got < n && cyc < 2000) begin
            if (held) begin
                n_cmp++;
                if (read_data_valid !== 1'b1 || read_data !== hd) begin
                    n_fail++;
                    $display("FAIL resp_hold: valid=%b data=%h required valid=1 data=%h",
                             read_data_valid, read_data, hd);
                end
            end
            resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (read_data_valid === 1'b1) begin
                if (resp_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_extra: data=%h required no response", read_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (read_data !== e) begin
                            n_fail++;
                            $display("FAIL resp_data: data=%h required %h", read_data, e);
                        end
                    end
                    got++;
                end else begin
                    held = 1'b1;
                    hd = read_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        resp_ready = 1'b0;
        n_cmp++;
        if (got != n) begin
            n_fail++;
            $display("FAIL resp_count: got=%0d required %0d", got, n);
        end
    endtask

    task automatic chk_err(input string nm, input logic expv);
        n_cmp++;
        if (burst_err !== expv) begin
            n_fail++;
            $display("FAIL %s: burst_err=%b required %b", nm, burst_err, expv);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_F000) | ((32'd512 + 32'($urandom_range(0, 31))) << 2);
        return a;
    endfunction

    task automatic test_reset();
        rest = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (request_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready_during: ready=%b required 0", request_ready);
        end
        rest = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (request_ready !== 1'b1 || read_data_valid !== 1'b0 || read_data !== 32'd0 || burst_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_values: ready=%b valid=%b data=%h err=%b required 1 0 00000000 0",
                     request_ready, read_data_valid, read_data, burst_err);
        end
    endtask

    task automatic test_single();
        do_beat(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 8'd0);
        do_beat(1, 0, 32'h10, 32'h0, 4'h0, 0, 8'd0);
        n_cmp++;
        if (read_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_latency_early: valid=%b required 0", read_data_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (read_data_valid !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_latency_2: valid=%b data=%h required 1 deadbeef", read_data_valid, read_data);
        end
        drain(1, 0);
    endtask

    task automatic test_byte_lanes();
        do_beat(0, 1, 32'h20, 32'h11223344, 4'b1111, 0, 8'd0);
        do_beat(0, 1, 32'h20, 32'hAABBCCDD, 4'b0011, 0, 8'd0);
        do_beat(1, 0, 32'h20, 32'h0, 4'h0, 0, 8'd0);
        @(negedge clk);
        n_cmp++;
        if (read_data !== 32'h1122CCDD) begin
            n_fail++; $display("FAIL byte_lanes: data=%h required 1122ccdd", read_data);
        end
        drain(1, 0);
    endtask

    task automatic test_burst();
        int e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            do_beat(0, 1, 32'h100 + 32'(4*i), 32'(i + 1), 4'hF, (i == 0), 8'(3 - i));
            chk_err("burst_wr_err", 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            do_beat(1, 0, 32'h100 + 32'(4*i), 32'h0, 4'h0, (i == 0), 8'(3 - i));
            chk_err("burst_rd_err", 1'b0);
        end
        drain(4, 0);
        n_cmp++;
        if (err_cnt != e0) begin
            n_fail++; $display("FAIL burst_err_count: pulses=%0d required 0", err_cnt - e0);
        end
    endtask

    task automatic test_violation();
        int e0;
        do_beat(0, 1, 32'h200, 32'hA0A0A0A0, 4'hF, 1, 8'd1);
        chk_err("viol_first_beat", 1'b0);
        e0 = err_cnt;
        do_beat(0, 1, 32'h208, 32'hB0B0B0B0, 4'hF, 0, 8'd0);
        chk_err("viol_addr", 1'b1);
        @(negedge clk);
        chk_err("viol_pulse_width", 1'b0);
        n_cmp++;
        if (err_cnt != e0 + 1) begin
            n_fail++; $display("FAIL viol_pulse_count: pulses=%0d required 1", err_cnt - e0);
        end
        do_beat(1, 1, 32'h210, 32'hC0C0C0C0, 4'hF, 0, 8'd0);
        chk_err("viol_rd_and_wr", 1'b1);
        do_beat(0, 1, 32'h220, 32'h22222222, 4'hF, 1, 8'd20);
        chk_err("viol_count_max", 1'b1);
        do_beat(0, 1, 32'h230, 32'h33333333, 4'hF, 1, 8'd0);
        chk_err("viol_begin_in_burst", 1'b1);
        do_beat(0, 1, 32'h240, 32'h44444444, 4'hF, 0, 8'd0);
        chk_err("viol_back_to_idle", 1'b0);
        do_beat(1, 0, 32'h200, 32'h0, 4'h0, 1, 8'd1);
        chk_err("viol_rd_burst_start", 1'b0);
        do_beat(0, 1, 32'h204, 32'h55555555, 4'hF, 0, 8'd0);
        chk_err("viol_direction", 1'b1);
        do_beat(1, 0, 32'h208, 32'h0, 4'h0, 0, 8'd0);
        chk_err("viol_single_after", 1'b0);
        do_beat(1, 0, 32'h210, 32'h0, 4'h0, 0, 8'd0);
        do_beat(1, 0, 32'h204, 32'h0, 4'h0, 0, 8'd0);
        drain(4, 0);
    endtask

    task automatic test_random();
        int nrd = 0;
        int e0;
        bit          op_rd [80];
        logic [31:0] op_a  [80];
        logic [31:0] op_d  [80];
        logic [3:0]  op_be [80];
        for (int i = 0; i < 32; i++)
            do_beat(0, 1, (32'd512 + 32'(i)) << 2, $urandom, 4'hF, 0, 8'd0);
        for (int i = 0; i < 80; i++) begin
            op_rd[i] = 1'($urandom_range(0, 1));
            op_a[i]  = rnd_addr();
            op_d[i]  = $urandom;
            op_be[i] = 4'($urandom_range(0, 15));
            if (op_rd[i]) nrd++;
        end
        e0 = err_cnt;
        fork
            begin
                for (int i = 0; i < 80; i++)
                    do_beat(op_rd[i], !op_rd[i], op_a[i], op_d[i], op_be[i], 0, 8'd0);
            end
            drain(nrd, 1);
        join
        n_cmp++;
        if (exp_q.size() != 0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL random_leftover: queued=%0d err_pulses=%0d required 0 0", exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_beat(1, 0, rnd_addr(), 32'h0, 4'h0, 0, 8'd0);
            if (i == 2) begin
                n_cmp++;
                if (request_ready !== 1'b1) begin
                    n_fail++; $display("FAIL bp_ready_3: ready=%b required 1", request_ready);
                end
            end
        end
        n_cmp++;
        if (request_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_4: ready=%b required 0", request_ready);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (request_ready !== 1'b0 || read_data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stalled: ready=%b valid=%b required 0 1", request_ready, read_data_valid);
        end
        fork
            begin
                do_beat(1, 0, rnd_addr(), 32'h0, 4'h0, 0, 8'd0);
                do_beat(1, 0, rnd_addr(), 32'h0, 4'h0, 0, 8'd0);
            end
            drain(6, 1);
        join
        resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (read_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_duplicate: valid=%b required 0", read_data_valid);
            end
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_beat(1, 0, rnd_addr(), 32'h0, 4'h0, 0, 8'd0);
        n_cmp++;
        if (read_data_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmid_queued: valid=%b required 1", read_data_valid);
        end
        rest = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (read_data_valid !== 1'b0 || request_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_flush: valid=%b ready=%b required 0 0", read_data_valid, request_ready);
        end
        rest = 1'b0;
        exp_q.delete();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (read_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL rmid_stale: valid=%b data=%h required 0", read_data_valid, read_data);
            end
        end
        resp_ready = 1'b0;
        do_beat(1, 0, 32'h10, 32'h0, 4'h0, 0, 8'd0);
        @(negedge clk);
        n_cmp++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rmid_ram_kept: data=%h required deadbeef", read_data);
        end
        drain(1, 0);
    endtask

    initial begin
        rest = 1'b1; address = 32'd0; byte_en = 4'h0; read = 1'b0; write = 1'b0;
        write_data = 32'd0; begin_burst_transfer = 1'b0; burst_count = 8'd0; resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_byte_lanes();
        test_burst();
        test_violation();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
